// File: rtl/pipe_hazard_ctrl_if.sv
// Core <-> hazard controller signal bundle: ID/EX/MEM/WB hazard sources,
// interrupt handshake, and the stage enable/flush/forwarding controls.
`timescale 1ns/1ps
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] i_id_rs, i_id_rt;
    logic              i_id_use_rs, i_id_use_rt, i_id_jump;
    logic [REG_AW-1:0] i_ex_rd;
    logic              i_ex_regwrite, i_ex_lw, i_ex_br_taken, i_ex_muldiv_start;
    logic [REG_AW-1:0] i_mem_rd, i_wb_rd;
    logic              i_mem_regwrite, i_wb_regwrite;
    logic              i_ext_int, i_int_en, i_int_ack;
    logic              o_we_pc, o_we_dec, o_we_exec, o_we_MemAc, o_we_WrBc;
    logic              o_s_rst_dec, o_s_rst_exec, o_s_rst_MemAc, o_s_rst_WrBc;
    logic [1:0]        o_fwd_a, o_fwd_b;
    logic              o_int_req, o_busy;

    modport master (
        output i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_jump,
               i_ex_rd, i_ex_regwrite, i_ex_lw, i_ex_br_taken, i_ex_muldiv_start,
               i_mem_rd, i_wb_rd, i_mem_regwrite, i_wb_regwrite,
               i_ext_int, i_int_en, i_int_ack,
        input  o_we_pc, o_we_dec, o_we_exec, o_we_MemAc, o_we_WrBc,
               o_s_rst_dec, o_s_rst_exec, o_s_rst_MemAc, o_s_rst_WrBc,
               o_fwd_a, o_fwd_b, o_int_req, o_busy
    );

    modport slave (
        input  i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_jump,
               i_ex_rd, i_ex_regwrite, i_ex_lw, i_ex_br_taken, i_ex_muldiv_start,
               i_mem_rd, i_wb_rd, i_mem_regwrite, i_wb_regwrite,
               i_ext_int, i_int_en, i_int_ack,
        output o_we_pc, o_we_dec, o_we_exec, o_we_MemAc, o_we_WrBc,
               o_s_rst_dec, o_s_rst_exec, o_s_rst_MemAc, o_s_rst_WrBc,
               o_fwd_a, o_fwd_b, o_int_req, o_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/interrupt controller for the 5-stage MIPS pipeline: flushes,
// load-use stall, operand forwarding, mul/div freeze and gated interrupt request.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MULDIV_LAT = 4,
    parameter int INT_SYNC   = 2
) (
    input logic              i_clk,
    input logic              i_a_rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int CW = $clog2(MULDIV_LAT + 1);

    typedef enum logic {ST_RUN, ST_MD_BUSY} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_md_cnt;
    logic                  r_busy;
    logic [INT_SYNC-1:0]   r_sync;
    logic                  r_edge;
    logic                  r_int_pend;

    logic w_active, w_run, w_lu_match, w_br, w_lu, w_jmp, w_md_go, w_int_edge;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd
    );
        if (mem_we && (mem_rd != '0) && (mem_rd == src))
            return 2'b01;
        else if (wb_we && (wb_rd != '0) && (wb_rd == src))
            return 2'b10;
        return 2'b00;
    endfunction

    assign w_lu_match = hz.i_ex_lw & hz.i_ex_regwrite & (hz.i_ex_rd != '0) &
                        ((hz.i_id_use_rs & (hz.i_id_rs == hz.i_ex_rd)) |
                         (hz.i_id_use_rt & (hz.i_id_rt == hz.i_ex_rd)));

    // Outputs fall back to their reset values for as long as reset is held.
    assign w_active   = ~i_a_rst;
    assign w_run      = w_active & (r_state == ST_RUN);
    assign w_br       = w_run & hz.i_ex_br_taken;
    assign w_lu       = w_run & ~hz.i_ex_br_taken & w_lu_match;
    assign w_jmp      = w_run & ~hz.i_ex_br_taken & ~w_lu_match & hz.i_id_jump;
    assign w_md_go    = w_run & ~hz.i_ex_br_taken & ~w_lu_match & ~hz.i_id_jump &
                        hz.i_ex_muldiv_start;
    assign w_int_edge = r_sync[INT_SYNC-1] & ~r_edge;

    assign hz.o_busy  = r_busy;

    always_comb begin
        hz.o_we_pc       = 1'b1;
        hz.o_we_dec      = 1'b1;
        hz.o_we_exec     = 1'b1;
        hz.o_we_MemAc    = 1'b1;
        hz.o_we_WrBc     = 1'b1;
        hz.o_s_rst_dec   = 1'b0;
        hz.o_s_rst_exec  = 1'b0;
        hz.o_s_rst_MemAc = 1'b0;
        hz.o_s_rst_WrBc  = 1'b0;
        hz.o_fwd_a       = 2'b00;
        hz.o_fwd_b       = 2'b00;
        hz.o_int_req     = 1'b0;
        if (w_active) begin
            hz.o_fwd_a = fwd_sel(hz.i_id_rs, hz.i_mem_regwrite, hz.i_mem_rd,
                                 hz.i_wb_regwrite, hz.i_wb_rd);
            hz.o_fwd_b = fwd_sel(hz.i_id_rt, hz.i_mem_regwrite, hz.i_mem_rd,
                                 hz.i_wb_regwrite, hz.i_wb_rd);
            if (r_busy) begin
                // Hold PC..EX and feed bubbles into MEM while mul/div runs.
                hz.o_we_pc       = 1'b0;
                hz.o_we_dec      = 1'b0;
                hz.o_we_exec     = 1'b0;
                hz.o_s_rst_MemAc = 1'b1;
            end else begin
                if (w_br) begin
                    hz.o_s_rst_dec  = 1'b1;
                    hz.o_s_rst_exec = 1'b1;
                end
                if (w_lu) begin
                    hz.o_we_pc      = 1'b0;
                    hz.o_we_dec     = 1'b0;
                    hz.o_s_rst_exec = 1'b1;
                end
                if (w_jmp)
                    hz.o_s_rst_dec = 1'b1;
                hz.o_int_req = r_int_pend & hz.i_int_en & ~(w_br | w_lu | w_jmp);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            r_state  <= ST_RUN;
            r_md_cnt <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_md_go) begin
                        r_state  <= ST_MD_BUSY;
                        r_md_cnt <= CW'(MULDIV_LAT - 1);
                        r_busy   <= 1'b1;
                    end
                end
                default: begin
                    r_md_cnt <= r_md_cnt - 1'b1;
                    if (r_md_cnt == CW'(1)) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // A fresh edge beats a simultaneous acknowledge so no interrupt is lost.
    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            r_sync     <= '0;
            r_edge     <= 1'b0;
            r_int_pend <= 1'b0;
        end else begin
            r_sync <= {r_sync[INT_SYNC-2:0], hz.i_ext_int};
            r_edge <= r_sync[INT_SYNC-1];
            if (w_int_edge)
                r_int_pend <= 1'b1;
            else if (hz.i_int_ack)
                r_int_pend <= 1'b0;
        end
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard, stall and interrupt controller for the 5-stage pipelined MIPS core. It drives the stage write-enables and synchronous stage resets that are currently tied off at the core top level. It also generates operand forwarding selects and throttles a multi-cycle mul/div unit. External interrupts are synchronised into a pending request that is presented to the core only when the pipeline is quiescent.

Parameters:
REG_AW, 5, register-address width
MULDIV_LAT, 4, EX-stage cycles taken by one mul/div op (>=2)
INT_SYNC, 2, synchroniser flops on i_ext_int (>=2)

Ports:
i_clk  in  1  clock
i_a_rst  in  1  reset; asynchronous, active-high
i_id_rs, i_id_rt  in  REG_AW each  ID-stage source regs
i_id_use_rs, i_id_use_rt  in  1 each  ID instr actually reads rs/rt
i_id_jump  in  1  J/JAL decoded in ID
i_ex_rd  in  REG_AW  EX destination reg
i_ex_regwrite  in  1  EX instr writes a reg
i_ex_lw  in  1  EX instr is a load
i_ex_br_taken  in  1  branch/JR resolved taken in EX
i_ex_muldiv_start  in  1  mul/div op entering EX
i_mem_rd, i_wb_rd  in  REG_AW each  MEM/WB destination regs
i_mem_regwrite, i_wb_regwrite  in  1 each  MEM/WB reg writes
i_ext_int  in  1  async external interrupt level
i_int_en  in  1  CP0 status interrupt enable
i_int_ack  in  1  core has taken the interrupt (EPC written)
o_we_pc, o_we_dec, o_we_exec, o_we_MemAc, o_we_WrBc  out  1 each  stage register write-enables
o_s_rst_dec, o_s_rst_exec, o_s_rst_MemAc, o_s_rst_WrBc  out  1 each  synchronous stage bubble/flush
o_fwd_a, o_fwd_b  out  2 each  operand select: 00 regfile, 01 MEM result, 10 WB result
o_int_req  out  1  interrupt request to core
o_busy  out  1  mul/div in progress

Behaviour:
- Reset state: FSM = RUN; md_cnt = 0; sync flops, edge register and int_pend all 0.
- Reset output values: all o_we_* = 1; all o_s_rst_* = 0; o_fwd_* = 00; o_int_req = 0; o_busy = 0.
- Reset asserted mid-operation aborts mul/div and drops int_pend immediately.
- Forwarding (combinational): select 01 if MEM writes a non-zero rd equal to the source; else 10 if WB writes a non-zero rd equal to the source; else 00.
  - Register 0 is never forwarded.
  - MEM takes priority over WB on a double match.
- FSM state RUN, evaluated in priority order (first matching rule applies):
  1. Branch flush, when i_ex_br_taken: o_s_rst_dec = 1, o_s_rst_exec = 1, o_we_pc = 1.
  2. Load-use stall, when i_ex_lw & i_ex_regwrite & i_ex_rd != 0 and i_ex_rd matches a used ID source: o_we_pc = 0, o_we_dec = 0, o_s_rst_exec = 1. Lasts exactly 1 cycle; the next cycle sees the load in MEM and forwards it.
  3. Jump, when i_id_jump: o_s_rst_dec = 1.
  4. Mul/div start, when i_ex_muldiv_start: go to MD_BUSY, load md_cnt = MULDIV_LAT-1.
- FSM state MD_BUSY:
  - o_busy = 1; o_we_pc = o_we_dec = o_we_exec = 0; o_s_rst_MemAc = 1.
  - md_cnt decrements each cycle; leave for RUN on the cycle md_cnt == 1.
  - Total freeze is MULDIV_LAT-1 cycles.
  - Branch, jump and load-use inputs are ignored; i_ex_muldiv_start is ignored while busy.
- o_we_MemAc and o_we_WrBc stay 1 and o_s_rst_WrBc stays 0 at all times, so older instructions always drain.
- Interrupt path:
  - i_ext_int passes through INT_SYNC flops; a rising edge of the synchronised level sets int_pend.
  - o_int_req = int_pend & i_int_en & FSM == RUN & no stall or flush active this cycle.
  - i_int_ack clears int_pend. A new edge in the same cycle as i_int_ack wins: int_pend stays 1.
  - Level held high produces only one request.

Test Plan:
1. Forwarding: MEM rd = 3 and WB rd = 3, both writing, ID rs = 3 used -> o_fwd_a = 01. Same with rd = 0 -> o_fwd_a = 00.
2. Load-use: lw to r5 in EX, ID uses rt = 5 -> exactly 1 cycle of o_we_pc = 0, o_we_dec = 0, o_s_rst_exec = 1. Next cycle o_fwd_b = 01.
3. Mul/div with MULDIV_LAT = 4: start pulse -> o_busy high 3 cycles with PC/dec/exec frozen. A second start and a taken branch applied during busy have no effect.
4. Priority: i_ex_br_taken together with a load-use match and i_id_jump -> only the branch flush pattern appears; o_we_pc = 1.
5. Interrupt: pulse i_ext_int -> o_int_req rises INT_SYNC+1 cycles later. Hold i_int_en = 0 -> no request until enabled. i_int_ack -> request drops next cycle.
6. Reset: assert i_a_rst during MD_BUSY and with int_pend set -> all outputs return to reset values asynchronously. After release, o_busy = 0 and o_int_req = 0.
